// File: rtl/two_clk_phase_diff.sv
// two_clk_phase_diff
// Recovers the DDS frequency word from a phase stream: differences successive
// phase samples in count_clk, averages 2^AVG_LOG2 deltas, and hands each result
// to the out_clk domain through a toggle req/ack handshake.
// Optional build macro: TWO_CLK_PHASE_DIFF_SIGNED_EN (signed deltas, arithmetic averaging).
module two_clk_phase_diff #(
   parameter int PHASE_BITS   = 32,
   parameter int INC_BITS     = 32,
   parameter int AVG_LOG2     = 4,
   parameter int OUT_BUS_SIZE = 32
) (
   input  logic                    count_clk,
   input  logic                    rst,
   input  logic                    out_clk,
   input  logic                    sync_i,
   input  logic [PHASE_BITS-1:0]   phase_in,
   input  logic                    phase_valid_i,
   output logic [OUT_BUS_SIZE-1:0] inc_out,
   output logic                    inc_valid_o,
   output logic                    overrun_o
);

   localparam int SUM_W = INC_BITS + AVG_LOG2;
   localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

   typedef enum logic {PRIME, ACCUM} state_t;

   // Widen one delta into the accumulator width.
   function automatic logic [SUM_W-1:0] extend_delta(input logic [INC_BITS-1:0] d);
`ifdef TWO_CLK_PHASE_DIFF_SIGNED_EN
      logic signed [INC_BITS-1:0] ds;
      ds = $signed(d);
      return SUM_W'(ds);
`else
      return SUM_W'(d);
`endif
   endfunction

   // Divide the window sum by 2^AVG_LOG2 (truncating) and keep INC_BITS.
   function automatic logic [INC_BITS-1:0] avg_shift(input logic [SUM_W-1:0] s);
`ifdef TWO_CLK_PHASE_DIFF_SIGNED_EN
      logic signed [SUM_W-1:0] ss;
      ss = $signed(s);
      return INC_BITS'(ss >>> AVG_LOG2);
`else
      return INC_BITS'(s >> AVG_LOG2);
`endif
   endfunction

   state_t                  state, state_next;
   logic [PHASE_BITS-1:0]   phase_prev;
   logic [SUM_W-1:0]        sum;
   logic [CNT_W-1:0]        cnt;
   logic [INC_BITS-1:0]     hold;
   logic                    req_tog, ack_s1, ack_sync;
   logic                    req_s1, req_sync, ack_tog;
   logic                    take_sample, accum_en, win_done, busy;
   logic [INC_BITS-1:0]     delta, result;
   logic [SUM_W-1:0]        sum_next;

   // Modular phase difference and window arithmetic.
   assign delta    = INC_BITS'(phase_in - phase_prev);
   assign sum_next = sum + extend_delta(delta);
   assign result   = avg_shift(sum_next);
   assign busy     = (req_tog != ack_sync);

   // FSM state register.
   always_ff @(posedge count_clk or negedge rst) begin
      if (!rst) state <= PRIME;
      else      state <= state_next;
   end

   // FSM next state and datapath strobes; sync_i wins over a valid sample.
   always_comb begin
      state_next  = state;
      take_sample = 1'b0;
      accum_en    = 1'b0;
      win_done    = 1'b0;
      if (sync_i) begin
         state_next = PRIME;
      end else if (phase_valid_i) begin
         take_sample = 1'b1;
         if (state == PRIME) begin
            state_next = ACCUM;
         end else begin
            accum_en = 1'b1;
            win_done = (cnt == CNT_LAST);
         end
      end
   end

   // Accumulate deltas, close windows, and publish when the handoff is free.
   always_ff @(posedge count_clk or negedge rst) begin
      if (!rst) begin
         phase_prev <= '0;
         sum        <= '0;
         cnt        <= '0;
         hold       <= '0;
         req_tog    <= 1'b0;
         overrun_o  <= 1'b0;
      end else begin
         if (take_sample) phase_prev <= phase_in;
         if (sync_i) begin
            sum <= '0;
            cnt <= '0;
         end else if (accum_en) begin
            if (win_done) begin
               sum <= '0;
               cnt <= '0;
               if (!busy) begin
                  hold    <= result;
                  req_tog <= ~req_tog;
               end else begin
                  overrun_o <= 1'b1;
               end
            end else begin
               sum <= sum_next;
               cnt <= cnt + CNT_W'(1);
            end
         end
      end
   end

   // Bring the acknowledge toggle back into count_clk.
   always_ff @(posedge count_clk or negedge rst) begin
      if (!rst) begin
         ack_s1   <= 1'b0;
         ack_sync <= 1'b0;
      end else begin
         ack_s1   <= ack_tog;
         ack_sync <= ack_s1;
      end
   end

   // Synchronise the request toggle, load hold on its edge, and echo it as ack.
   always_ff @(posedge out_clk or negedge rst) begin
      if (!rst) begin
         req_s1      <= 1'b0;
         req_sync    <= 1'b0;
         ack_tog     <= 1'b0;
         inc_out     <= '0;
         inc_valid_o <= 1'b0;
      end else begin
         req_s1      <= req_tog;
         req_sync    <= req_s1;
         ack_tog     <= req_sync;
         inc_valid_o <= 1'b0;
         if (req_sync != ack_tog) begin
            inc_out     <= OUT_BUS_SIZE'(hold);
            inc_valid_o <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_two_clk_phase_diff.sv
// Scoreboard bench for two_clk_phase_diff (AVG_LOG2=2, 32-bit buses).
`timescale 1ns/1ps
module tb_two_clk_phase_diff;

   logic        count_clk = 1'b0;
   logic        out_clk   = 1'b0;
   logic        out_run   = 1'b1;
   logic        rst       = 1'b0;
   logic        sync_i    = 1'b0;
   logic        phase_valid_i = 1'b0;
   logic [31:0] phase_in  = '0;
   logic [31:0] inc_out;
   logic        inc_valid_o;
   logic        overrun_o;

   logic [31:0] exp_q[$];
   int          checks   = 0;
   int          failures = 0;

   two_clk_phase_diff #(
      .PHASE_BITS(32), .INC_BITS(32), .AVG_LOG2(2), .OUT_BUS_SIZE(32)
   ) dut (
      .count_clk(count_clk), .rst(rst), .out_clk(out_clk), .sync_i(sync_i),
      .phase_in(phase_in), .phase_valid_i(phase_valid_i),
      .inc_out(inc_out), .inc_valid_o(inc_valid_o), .overrun_o(overrun_o)
   );

   always #5 count_clk = ~count_clk;
   always begin
      #7;
      if (out_run) out_clk = ~out_clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: every published result must match the oldest expected one.
   always @(negedge out_clk) begin
      if (inc_valid_o === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pulse: got inc_out=0x%08h with no result expected", inc_out);
         end else begin
            check("inc_out", inc_out, exp_q.pop_front());
         end
      end
   end

   task automatic send(input logic [31:0] p);
      @(negedge count_clk);
      sync_i        = 1'b0;
      phase_in      = p;
      phase_valid_i = 1'b1;
   endtask

   task automatic resync();
      @(negedge count_clk);
      sync_i        = 1'b1;
      phase_valid_i = 1'b1;
      phase_in      = 32'hDEADBEEF;
   endtask

   task automatic idle(input int n);
      @(negedge count_clk);
      phase_valid_i = 1'b0;
      sync_i        = 1'b0;
      repeat (n) @(negedge count_clk);
   endtask

   task automatic ramp(input logic [31:0] start, input logic [31:0] step, input int n);
      for (int i = 0; i < n; i++) send(start + step * 32'(i));
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge count_clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout: got %0d results pending, required 0", name, exp_q.size());
         exp_q.delete();
      end
      repeat (12) @(negedge count_clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #23;
      check("rst_inc_out", inc_out, 32'h0);
      check("rst_inc_valid", {31'b0, inc_valid_o}, 32'h0);
      check("rst_overrun", {31'b0, overrun_o}, 32'h0);
      @(negedge count_clk);
      #2 rst = 1'b1;
      idle(3);

      // 1: simple ramp from reset (FSM already priming)
      exp_q.push_back(32'h01000000);
      ramp(32'h0, 32'h01000000, 5);
      idle(2);
      drain("ramp");

      // 2: ramp that wraps through zero
      exp_q.push_back(32'h02000000);
      resync();
      ramp(32'hFF000000, 32'h02000000, 5);
      idle(2);
      drain("wrap");
      check("wrap_overrun", {31'b0, overrun_o}, 32'h0);

      // 3: one negative-looking delta
`ifdef TWO_CLK_PHASE_DIFF_SIGNED_EN
      exp_q.push_back(32'h00000008);
`else
      exp_q.push_back(32'h40000008);
`endif
      resync();
      send(32'h0); send(32'h10); send(32'h20); send(32'h30); send(32'h20);
      idle(2);
      drain("neg_delta");

      // 4: sync_i mid-window discards the partial window
      exp_q.push_back(32'h00000200);
      resync();
      ramp(32'h0, 32'h100, 3);
      resync();
      ramp(32'h1000, 32'h200, 5);
      idle(2);
      drain("sync_restart");

      // 5: out_clk stopped, two windows -> second dropped
      out_run = 1'b0;
      #30;
      resync();
      ramp(32'h0, 32'h300, 9);
      idle(3);
      check("overrun_set", {31'b0, overrun_o}, 32'h1);
      exp_q.push_back(32'h00000300);
      out_run = 1'b1;
      drain("overrun_resume");
      check("overrun_sticky", {31'b0, overrun_o}, 32'h1);

      // 6: reset in the middle of a handoff
      out_run = 1'b0;
      #30;
      resync();
      ramp(32'h0, 32'h400, 5);
      idle(3);
      @(negedge count_clk);
      rst = 1'b0;
      #1;
      check("midrst_inc_out", inc_out, 32'h0);
      check("midrst_inc_valid", {31'b0, inc_valid_o}, 32'h0);
      check("midrst_overrun", {31'b0, overrun_o}, 32'h0);
      out_run = 1'b1;
      repeat (5) @(negedge count_clk);
      #2 rst = 1'b1;
      idle(3);
      exp_q.push_back(32'h00000500);
      ramp(32'h10000000, 32'h500, 5);
      idle(2);
      drain("post_reset_ramp");
      check("post_reset_overrun", {31'b0, overrun_o}, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
